// File: rtl/encrip.sv
// Chained stream cipher: 3-bit symbols extended with two parity bits, XORed
// with a 5-bit LFSR keystream, rotated, then chained with the previous output.
module encrip (
  input  logic       nRST,
  input  logic       clk,
  input  logic [2:0] Din,
  output logic [4:0] ECRo
);

  localparam logic [4:0] KEY_SEED = 5'b10101;

  logic [4:0] k;
  logic [4:0] k_next;
  logic [4:0] plain;
  logic [4:0] mix;
  logic [4:0] mix_rot;

  always_comb begin
    plain   = {Din, Din[2] ^ Din[1] ^ Din[0], Din[2] ^ Din[0]};
    mix     = plain ^ k;
    mix_rot = {mix[3:0], mix[4]};
    // x^5+x^3+1; the nonzero seed is the only guard against the all-zero state
    k_next  = {k[3:0], k[4] ^ k[2]};
  end

  // nRST is active-high despite its name
  always_ff @(posedge clk) begin
    if (nRST) begin
      ECRo <= 5'b00000;
      k    <= KEY_SEED;
    end else begin
      ECRo <= mix_rot ^ ECRo;
      k    <= k_next;
    end
  end

endmodule

// File: tb/tb_encrip.sv
// Directed bench for encrip: vector table, mid-stream reset, keystream
// period and round-trip decryption against an independent decrypt model.
module tb_encrip;

  logic       nRST;
  logic       clk;
  logic [2:0] Din;
  logic [4:0] ECRo;

  int checks = 0;
  int errors = 0;

  encrip dut (
    .nRST (nRST),
    .clk  (clk),
    .Din  (Din),
    .ECRo (ECRo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] din;
    logic [4:0] exp_ecro;
    logic [4:0] exp_k;
  } vec_t;

  vec_t vecs [10];

  task automatic step(input logic rst, input logic [2:0] din);
    nRST = rst;
    Din  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  logic [4:0] ks [62];
  logic [4:0] c_prev;
  logic [4:0] k_prev;
  logic [4:0] x;
  logic [4:0] rec;
  logic [2:0] d;
  logic [4:0] exp_p;

  initial begin
    vecs[0] = '{1'b1, 3'b110, 5'b00000, 5'b10101};
    vecs[1] = '{1'b0, 3'b000, 5'b01011, 5'b01010};
    vecs[2] = '{1'b0, 3'b001, 5'b10001, 5'b10100};
    vecs[3] = '{1'b0, 3'b010, 5'b01100, 5'b01000};
    vecs[4] = '{1'b0, 3'b111, 5'b00001, 5'b10000};
    vecs[5] = '{1'b0, 3'b111, 5'b11101, 5'b00001};
    vecs[6] = '{1'b1, 3'b101, 5'b00000, 5'b10101};
    vecs[7] = '{1'b1, 3'b011, 5'b00000, 5'b10101};
    vecs[8] = '{1'b0, 3'b000, 5'b01011, 5'b01010};
    vecs[9] = '{1'b0, 3'b001, 5'b10001, 5'b10100};

    nRST = 1'b1;
    Din  = 3'b000;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].din);
      check5($sformatf("vec%0d_ecro", i), ECRo, vecs[i].exp_ecro);
      check5($sformatf("vec%0d_k", i), dut.k, vecs[i].exp_k);
    end

    // Mid-stream reset: scramble with 001..111, then reset and replay
    for (int v = 1; v < 8; v++) step(1'b0, 3'(v));
    step(1'b1, 3'b010);
    check5("midrst_ecro", ECRo, 5'b00000);
    check5("midrst_k", dut.k, 5'b10101);
    step(1'b0, 3'b000);
    check5("replay0_ecro", ECRo, 5'b01011);
    step(1'b0, 3'b001);
    check5("replay1_ecro", ECRo, 5'b10001);

    // Keystream: constant Din for 62 cycles
    step(1'b1, 3'b011);
    for (int i = 0; i < 62; i++) begin
      step(1'b0, 3'b011);
      ks[i] = dut.k;
    end
    for (int i = 0; i < 62; i++) begin
      checks++;
      if (ks[i] === 5'b00000) begin
        errors++;
        $display("FAIL ks_nonzero[%0d]: got %b expected nonzero", i, ks[i]);
      end
    end
    for (int i = 0; i < 31; i++) check5($sformatf("ks_period[%0d]", i), ks[i + 31], ks[i]);
    for (int i = 1; i < 31; i++) begin
      checks++;
      if (ks[i] === ks[0]) begin
        errors++;
        $display("FAIL ks_short_period[%0d]: got %b expected != %b", i, ks[i], ks[0]);
      end
    end

    // Round trip: decrypt with an independent model seeded like the DUT reset
    step(1'b1, 3'b000);
    c_prev = 5'b00000;
    k_prev = 5'b10101;
    for (int i = 0; i < 9; i++) begin
      d = (i == 8) ? 3'b000 : 3'(i);
      step(1'b0, d);
      x   = ECRo ^ c_prev;
      rec = {x[0], x[4:1]} ^ k_prev;
      exp_p = {d, d[2] ^ d[1] ^ d[0], d[2] ^ d[0]};
      check5($sformatf("roundtrip[%0d]", i), rec, exp_p);
      c_prev = ECRo;
      k_prev = {k_prev[3:0], k_prev[4] ^ k_prev[2]};
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encrip.md
ENCRIP -- requirements
Module: encrip

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset. The ports SHALL be named and ordered as listed below.
REQ-002 nRST  input  1  Synchronous reset. It is active-high despite its name: reset is applied at a rising clk edge while nRST=1.
REQ-003 clk  input  1  Rising-edge clock for all state.
REQ-004 Din  input  3  Plaintext symbol, sampled on every non-reset rising edge.
REQ-005 ECRo  output  5  Ciphertext symbol, driven directly from a register (no combinational path from Din).

Function
REQ-006 The block SHALL extend Din into a 5-bit plaintext word P = {Din[2:0], p1, p0}, where:
- p1 = Din[2]^Din[1]^Din[0]
- p0 = Din[2]^Din[0]
REQ-007 The block SHALL hold a 5-bit keystream register K, implemented as a Fibonacci LFSR: K_next = {K[3:0], K[4]^K[2]} (polynomial x^5+x^3+1, period 31).
REQ-008 The block SHALL hold a 5-bit chaining value C, equal to the current ECRo register content.
REQ-009 On each non-reset rising edge the block SHALL update both registers:
- ECRo <= rotl1(P ^ K) ^ C, where rotl1(x) = {x[3:0], x[4]}
- K <= K_next
REQ-010 Latency SHALL be one cycle: the Din value sampled at edge n determines ECRo immediately after edge n.
REQ-011 K SHALL advance exactly once per non-reset edge, regardless of the Din value. There is no enable and no stall.
REQ-012 K SHALL never reach 5'b00000. The block SHALL NOT include any lock-up recovery logic beyond the nonzero seed.
REQ-013 Identical consecutive Din values SHALL generally produce differing ECRo values, because of chaining and keystream advance. No special-case logic is permitted.
REQ-014 All arithmetic SHALL be bitwise XOR and rotation on 5-bit vectors. There SHALL be no carries and no width growth.
REQ-015 Unknown (X) Din outside reset is not supported. No X-handling logic is required.

Reset
REQ-016 When nRST=1 at a rising clk edge, the block SHALL set:
- ECRo <= 5'b00000
- K <= 5'b10101 (seed)
REQ-017 Reset SHALL take priority over the normal update in the same edge. Din is ignored during reset.
REQ-018 Reset asserted mid-stream SHALL restart the keystream and the chain from the seed state. No residual state is permitted.
REQ-019 Before the first reset, ECRo and K are undefined. The bench SHALL apply reset before checking.

Verification
REQ-020 Reset: hold nRST=1 for one edge -> ECRo=00000 and internal K=10101.
REQ-021 First symbol: release reset, apply Din=000 -> after the next edge ECRo=01011 and K=01010.
REQ-022 Second symbol: continuing REQ-021, apply Din=001 (P=00111) -> after the next edge ECRo=10001 and K=10100.
REQ-023 Mid-stream reset: encrypt Din=001..111 over several cycles, assert nRST=1 for one edge, then replay Din=000,001 -> ECRo=00000 after the reset edge, then 01011, then 10001.
REQ-024 Keystream: hold Din constant for 62 cycles after reset -> K repeats with period exactly 31 and is never 00000.
REQ-025 Round trip: a reference model decrypts each symbol as P = rotr1(ECRo ^ C_prev) ^ K_prev, with the reference model seeded to match the DUT at reset. For Din sweeping 000..111 and back to 000, the recovered P[4:2] SHALL equal each Din and P[1:0] SHALL match the parity rules of REQ-006.
